// File: rtl/slow_memory_param_if.sv
// rtl/slow_memory_param_if.sv - request/response bus between a cache and slow_memory_param.
// SLOW_MEMORY_BYTE_MASK_EN adds the mem_wmask byte-enable signal.
interface slow_memory_param_if #(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 28
);
  localparam int LINE_W = WORD_W * LINE_WORDS;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
`ifdef SLOW_MEMORY_BYTE_MASK_EN
  logic [LINE_W/8-1:0] mem_wmask;
`endif
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_busy;

  modport master (
`ifdef SLOW_MEMORY_BYTE_MASK_EN
    output mem_wmask,
`endif
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, mem_busy
  );

  modport slave (
`ifdef SLOW_MEMORY_BYTE_MASK_EN
    input  mem_wmask,
`endif
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, mem_busy
  );
endinterface

// File: rtl/slow_memory_param.sv
// rtl/slow_memory_param.sv - line-granular backing store with counter-based fixed latency.
// Optional byte-masked writes when SLOW_MEMORY_BYTE_MASK_EN is defined.
module slow_memory_param #(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 28,
  parameter int LATENCY    = 15
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [WORD_W*LINE_WORDS*DEPTH-1:0]    mem_init,
  slow_memory_param_if.slave                    bus
);
  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [LINE_W-1:0] r_wdata;
  logic              r_is_write;
  logic [LINE_W-1:0] r_rdata;
  logic              r_ready;
  logic              r_busy;
  logic [LINE_W-1:0] r_mem [DEPTH];
  logic [LINE_W-1:0] w_line_new;
  logic              w_commit;
  logic              w_addr_unused;

  // Upper address bits alias onto the same line.
  assign w_addr_unused = ^bus.mem_addr[ADDR_W-1:IDX_W];
  assign w_commit      = (r_state == S_WAIT) && (r_cnt == '0) && r_is_write;

`ifdef SLOW_MEMORY_BYTE_MASK_EN
  logic [LINE_W/8-1:0] r_wmask;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_wmask <= '0;
    end else if (r_state == S_IDLE && (bus.mem_read || bus.mem_write)) begin
      r_wmask <= bus.mem_wmask;
    end
  end

  always_comb begin
    w_line_new = r_mem[r_idx];
    for (int b = 0; b < LINE_W/8; b++) begin
      if (r_wmask[b]) begin
        w_line_new[8*b +: 8] = r_wdata[8*b +: 8];
      end
    end
  end
`else
  assign w_line_new = r_wdata;
`endif

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_mem[j] <= mem_init[j*LINE_W +: LINE_W];
      end
    end else if (w_commit) begin
      r_mem[r_idx] <= w_line_new;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.mem_read || bus.mem_write) begin
            r_idx      <= bus.mem_addr[IDX_W-1:0];
            r_wdata    <= bus.mem_wdata;
            // A simultaneous read wins; the write half is dropped.
            r_is_write <= bus.mem_write && !bus.mem_read;
            r_cnt      <= CNT_W'(LATENCY - 1);
            r_busy     <= 1'b1;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            if (!r_is_write) begin
              r_rdata <= r_mem[r_idx];
            end
          end
        end
        S_RESP: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rdata = r_rdata;
  assign bus.mem_ready = r_ready;
  assign bus.mem_busy  = r_busy;
endmodule

// File: tb/tb_slow_memory_param.sv
// tb/tb_slow_memory_param.sv - scoreboard bench for slow_memory_param at LATENCY 15 and 1.
module tb_slow_memory_param;
  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int DEPTH      = 64;
  localparam int ADDR_W     = 28;
  localparam int LINE_W     = WORD_W * LINE_WORDS;
  localparam int MASK_W     = LINE_W / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [LINE_W*DEPTH-1:0] init_img;

  slow_memory_param_if #(.WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) b0 ();
  slow_memory_param_if #(.WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) b1 ();

  slow_memory_param #(.WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS), .DEPTH(DEPTH),
                      .ADDR_W(ADDR_W), .LATENCY(15)) dut0 (
    .clk(clk), .rst(rst), .mem_init(init_img), .bus(b0));
  slow_memory_param #(.WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS), .DEPTH(DEPTH),
                      .ADDR_W(ADDR_W), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_init(init_img), .bus(b1));

  typedef struct {
    logic [LINE_W-1:0] data;
    int                e0;
  } exp_t;

  exp_t              q0[$];
  exp_t              q1[$];
  int                e0_last [2];
  int                lat [2];
  logic [LINE_W-1:0] model [2][DEPTH];
  logic [LINE_W-1:0] last_rd [2];
  int                ncnt = 0;
  int                checks = 0;
  int                errors = 0;

  always @(negedge clk) ncnt <= ncnt + 1;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    for (int id = 0; id < 2; id++) begin
      for (int j = 0; j < DEPTH; j++) model[id][j] = init_img[j*LINE_W +: LINE_W];
      last_rd[id] = '0;
      e0_last[id] = -1;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic mon(input int id, input logic rdy, input logic [LINE_W-1:0] rd, input logic bsy);
    exp_t e;
    logic eb;
    int   qsz;
    eb = (e0_last[id] >= 0) && (ncnt >= e0_last[id]) && (ncnt <= e0_last[id] + lat[id]);
    chk($sformatf("busy%0d@%0d", id, ncnt), LINE_W'(bsy), LINE_W'(eb));
    if (rdy) begin
      qsz = (id == 0) ? q0.size() : q1.size();
      if (qsz == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ready%0d at edge %0d got 1 expected 0", id, ncnt);
      end else begin
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        chk($sformatf("latency%0d", id), LINE_W'(ncnt - e.e0), LINE_W'(lat[id]));
        chk($sformatf("rdata%0d", id), rd, e.data);
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      mon(0, b0.mem_ready, b0.mem_rdata, b0.mem_busy);
      mon(1, b1.mem_ready, b1.mem_rdata, b1.mem_busy);
    end
  end

  task automatic drive(input int id, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] wd, input logic [MASK_W-1:0] wm);
    if (id == 0) begin
      b0.mem_read = rd; b0.mem_write = wr; b0.mem_addr = a; b0.mem_wdata = wd;
`ifdef SLOW_MEMORY_BYTE_MASK_EN
      b0.mem_wmask = wm;
`endif
    end else begin
      b1.mem_read = rd; b1.mem_write = wr; b1.mem_addr = a; b1.mem_wdata = wd;
`ifdef SLOW_MEMORY_BYTE_MASK_EN
      b1.mem_wmask = wm;
`endif
    end
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start(input int id, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] wd, input logic [MASK_W-1:0] wm);
    exp_t              e;
    int                idx;
    logic [MASK_W-1:0] m;
    idx = int'(a % DEPTH);
    m   = wm;
`ifndef SLOW_MEMORY_BYTE_MASK_EN
    m   = '1;
`endif
    @(posedge clk);
    drive(id, rd, wr, a, wd, wm);
    if (rd) begin
      e.data      = model[id][idx];
      last_rd[id] = e.data;
    end else begin
      for (int b = 0; b < MASK_W; b++)
        if (m[b]) model[id][idx][8*b +: 8] = wd[8*b +: 8];
      e.data = last_rd[id];
    end
    @(negedge clk);
    #1;
    e.e0        = ncnt;
    e0_last[id] = ncnt;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic finish_wait(input int id, input logic rd, input logic wr);
    bit seen = 1'b0;
    for (int i = 0; i < lat[id] + 4 && !seen; i++) begin
      @(posedge clk);
      // Scramble captured fields while the request is in flight.
      if (i == 0) drive(id, rd, wr, ADDR_W'($urandom), rnd_line(), MASK_W'($urandom));
      if ((id == 0) ? b0.mem_ready : b1.mem_ready) seen = 1'b1;
    end
    drive(id, 1'b0, 1'b0, '0, '0, '0);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout%0d got no ready expected ready within %0d cycles", id, lat[id] + 4);
    end
  endtask

  task automatic txn(input int id, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                     input logic [LINE_W-1:0] wd, input logic [MASK_W-1:0] wm);
    start(id, rd, wr, a, wd, wm);
    finish_wait(id, rd, wr);
  endtask

  initial begin
    int op;
    for (int j = 0; j < DEPTH; j++) init_img[j*LINE_W +: LINE_W] = rnd_line();
    init_img[5*LINE_W +: LINE_W]  = {16{8'hA5}};
    init_img[10*LINE_W +: LINE_W] = '0;
    lat[0] = 15;
    lat[1] = 1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    reset_model();
    repeat (3) @(posedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rdata0", b0.mem_rdata, '0);
    chk("rst_ready0", LINE_W'(b0.mem_ready), '0);
    chk("rst_busy0",  LINE_W'(b0.mem_busy), '0);
    chk("rst_rdata1", b1.mem_rdata, '0);
    chk("rst_ready1", LINE_W'(b1.mem_ready), '0);
    chk("rst_busy1",  LINE_W'(b1.mem_busy), '0);

    txn(0, 1'b1, 1'b0, 28'd5, '0, '0);
    chk("a5_line", b0.mem_rdata, {16{8'hA5}});
    txn(0, 1'b0, 1'b1, 28'd3, 128'h0123456789ABCDEF0123456789ABCDEF, '1);
    txn(0, 1'b1, 1'b0, 28'd3, '0, '0);
    chk("wr_rd_line3", b0.mem_rdata, 128'h0123456789ABCDEF0123456789ABCDEF);
    txn(0, 1'b1, 1'b0, 28'd71, '0, '0);
    chk("alias71", b0.mem_rdata, init_img[7*LINE_W +: LINE_W]);
    txn(0, 1'b1, 1'b0, 28'd63, '0, '0);
    txn(0, 1'b1, 1'b1, 28'd9, rnd_line(), '1);
    txn(0, 1'b1, 1'b0, 28'd9, '0, '0);
    chk("rw_both9", b0.mem_rdata, init_img[9*LINE_W +: LINE_W]);
    txn(1, 1'b1, 1'b1, 28'd9, rnd_line(), '1);
    txn(1, 1'b1, 1'b0, 28'd9, '0, '0);
    txn(1, 1'b1, 1'b0, 28'd5, '0, '0);

`ifdef SLOW_MEMORY_BYTE_MASK_EN
    txn(0, 1'b0, 1'b1, 28'd10, '1, 16'h000F);
    txn(0, 1'b1, 1'b0, 28'd10, '0, '0);
    chk("mask_line10", b0.mem_rdata, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
    txn(0, 1'b0, 1'b1, 28'd10, '1, 16'h0000);
    txn(0, 1'b1, 1'b0, 28'd10, '0, '0);
`endif

    for (int n = 0; n < 45; n++) begin
      op = $urandom_range(0, 2);
      txn((n % 3 == 2) ? 1 : 0, op != 1, op != 0, ADDR_W'($urandom), rnd_line(), MASK_W'($urandom));
    end

    start(0, 1'b0, 1'b1, 28'd2, rnd_line(), '1);
    repeat (8) @(negedge clk);
    @(posedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    reset_model();
    #1;
    chk("abort_rdata", b0.mem_rdata, '0);
    chk("abort_ready", LINE_W'(b0.mem_ready), '0);
    chk("abort_busy",  LINE_W'(b0.mem_busy), '0);
    repeat (3) @(posedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    txn(0, 1'b1, 1'b0, 28'd2, '0, '0);
    chk("abort_line2", b0.mem_rdata, init_img[2*LINE_W +: LINE_W]);

    repeat (4) @(posedge clk);
    chk("q0_drained", LINE_W'(q0.size()), '0);
    chk("q1_drained", LINE_W'(q1.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
